// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single synchronous RAM: port A (video) has priority,
// port B (game logic) is guaranteed a grant after MAX_WAIT consecutive denials.
module ram_arbiter #(
   parameter int ADDR_W   = 17,
   parameter int WDATA_W  = 8,
   parameter int RDATA_W  = 5,
   parameter int MAX_WAIT = 4
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               req_a,
   input  logic [ADDR_W-1:0]  addr_a,
   output logic               gnt_a,
   output logic               rvalid_a,
   output logic [RDATA_W-1:0] rdata_a,
   input  logic               req_b,
   input  logic               we_b,
   input  logic [ADDR_W-1:0]  addr_b,
   input  logic [WDATA_W-1:0] wdata_b,
   output logic               gnt_b,
   output logic               rvalid_b,
   output logic [RDATA_W-1:0] rdata_b,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic [WDATA_W-1:0] ram_din,
   output logic               ram_we,
   input  logic [RDATA_W-1:0] ram_dout,
   output logic               a_miss,
   output logic [7:0]         miss_cnt,
   input  logic               miss_clr
);

   typedef enum logic [1:0] {IDLE, RD_A, RD_B} owner_t;

   owner_t              owner_q, owner_d;
   logic [3:0]          wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic                a_miss_q, a_miss_d;
   logic [7:0]          miss_cnt_q, miss_cnt_d;
   logic                force_b;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         owner_q    <= IDLE;
         wait_cnt_q <= '0;
         ram_addr_q <= '0;
         a_miss_q   <= 1'b0;
         miss_cnt_q <= '0;
      end else begin
         owner_q    <= owner_d;
         wait_cnt_q <= wait_cnt_d;
         ram_addr_q <= ram_addr_d;
         a_miss_q   <= a_miss_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   always_comb begin
      // Grants are gated by reset so the RAM sees no access while Reset_n is low.
      force_b    = req_b && (wait_cnt_q == 4'(MAX_WAIT));
      gnt_b      = Reset_n && req_b && (force_b || !req_a);
      gnt_a      = Reset_n && req_a && !force_b;

      ram_addr_d = ram_addr_q;
      if (gnt_a)      ram_addr_d = addr_a;
      else if (gnt_b) ram_addr_d = addr_b;
      ram_addr   = ram_addr_d;
      ram_din    = wdata_b;
      ram_we     = gnt_b && we_b;

      wait_cnt_d = '0;
      if (req_b && !gnt_b)
         wait_cnt_d = (wait_cnt_q < 4'(MAX_WAIT)) ? wait_cnt_q + 4'd1 : wait_cnt_q;

      owner_d = IDLE;
      if (gnt_a)              owner_d = RD_A;
      else if (gnt_b && !we_b) owner_d = RD_B;

      a_miss_d   = req_a && !gnt_a;
      miss_cnt_d = miss_cnt_q;
      if (miss_clr)                           miss_cnt_d = '0;
      else if (a_miss_d && miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;

      rvalid_a = (owner_q == RD_A);
      rvalid_b = (owner_q == RD_B);
      rdata_a  = rvalid_a ? ram_dout : '0;
      rdata_b  = rvalid_b ? ram_dout : '0;
      a_miss   = a_miss_q;
      miss_cnt = miss_cnt_q;
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural sync RAM, vector table, read-data scoreboard,
// plus starvation/saturation and reset-mid-read sequences.
module tb_ram_arbiter;

   localparam int AW = 17;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        req_a = 1'b0, req_b = 1'b0, we_b = 1'b0, miss_clr = 1'b0;
   logic [AW-1:0] addr_a = '0, addr_b = '0;
   logic [7:0]  wdata_b = '0;
   logic        gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we, a_miss;
   logic [4:0]  rdata_a, rdata_b, ram_dout;
   logic [AW-1:0] ram_addr;
   logic [7:0]  ram_din, miss_cnt;

   ram_arbiter #(.ADDR_W(AW), .WDATA_W(8), .RDATA_W(5), .MAX_WAIT(4)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .req_a(req_a), .addr_a(addr_a), .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
      .a_miss(a_miss), .miss_cnt(miss_cnt), .miss_clr(miss_clr)
   );

   always #5 Clk = ~Clk;

   // Memory behind the arbiter and the bench's independent reference copy.
   logic [7:0] mem     [0:(1<<AW)-1];
   logic [7:0] ref_mem [0:(1<<AW)-1];

   always @(posedge Clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr][4:0];
   end

   typedef struct {
      logic       rva;
      logic       rvb;
      logic [4:0] data;
      logic       miss;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic          ra;
      logic [AW-1:0] aa;
      logic          rb;
      logic          wb;
      logic [AW-1:0] ab;
      logic [7:0]    db;
      logic          ega;
      logic          egb;
   } vec_t;

   int tests = 0;
   int fails = 0;
   logic [7:0]    exp_cnt = '0;
   logic [AW-1:0] last_addr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic reset_model();
      sb_q.delete();
      sb_q.push_back('{rva: 1'b0, rvb: 1'b0, data: 5'd0, miss: 1'b0});
      exp_cnt   = '0;
      last_addr = '0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".gnt_a"},    32'(gnt_a),    32'd0);
      chk({tag, ".gnt_b"},    32'(gnt_b),    32'd0);
      chk({tag, ".ram_we"},   32'(ram_we),   32'd0);
      chk({tag, ".ram_addr"}, 32'(ram_addr), 32'd0);
      chk({tag, ".rvalid_a"}, 32'(rvalid_a), 32'd0);
      chk({tag, ".rvalid_b"}, 32'(rvalid_b), 32'd0);
      chk({tag, ".a_miss"},   32'(a_miss),   32'd0);
      chk({tag, ".miss_cnt"}, 32'(miss_cnt), 32'd0);
   endtask

   // One clock cycle: inputs are applied now (just after a rising edge), checked at the falling edge.
   task automatic cycle(input logic ra, input logic [AW-1:0] aa, input logic rb, input logic wb,
                        input logic [AW-1:0] ab, input logic [7:0] db, input logic clr,
                        input logic ega, input logic egb, input string tag);
      sb_t exp_e;
      logic [AW-1:0] exp_addr;
      req_a = ra; addr_a = aa; req_b = rb; we_b = wb; addr_b = ab; wdata_b = db; miss_clr = clr;
      @(negedge Clk);
      if (sb_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         exp_e = sb_q.pop_front();
         chk({tag, ".rvalid_a"}, 32'(rvalid_a), 32'(exp_e.rva));
         chk({tag, ".rvalid_b"}, 32'(rvalid_b), 32'(exp_e.rvb));
         if (exp_e.rva) chk({tag, ".rdata_a"}, 32'(rdata_a), 32'(exp_e.data));
         if (exp_e.rvb) chk({tag, ".rdata_b"}, 32'(rdata_b), 32'(exp_e.data));
         chk({tag, ".a_miss"}, 32'(a_miss), 32'(exp_e.miss));
      end
      chk({tag, ".miss_cnt"}, 32'(miss_cnt), 32'(exp_cnt));
      chk({tag, ".gnt_a"},    32'(gnt_a),    32'(ega));
      chk({tag, ".gnt_b"},    32'(gnt_b),    32'(egb));
      chk({tag, ".ram_we"},   32'(ram_we),   32'(egb && wb));
      exp_addr = ega ? aa : (egb ? ab : last_addr);
      chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(exp_addr));
      if (egb && wb) chk({tag, ".ram_din"}, 32'(ram_din), 32'(db));
      exp_e.rva  = ega;
      exp_e.rvb  = egb && !wb;
      exp_e.data = ref_mem[exp_addr][4:0];
      exp_e.miss = ra && !ega;
      sb_q.push_back(exp_e);
      @(posedge Clk);
      if (clr)                                exp_cnt = '0;
      else if (ra && !ega && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      if (egb && wb) ref_mem[ab] = db;
      last_addr = exp_addr;
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, '0, 1'b0, 1'b0, addr_b, 8'h00, 1'b0, 1'b0, 1'b0, "idle");
   endtask

   vec_t vecs[8];

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]     = 8'(i * 13 + (i >> 7));
         ref_mem[i] = 8'(i * 13 + (i >> 7));
      end

      vecs[0] = '{ra:1, aa:17'h00123, rb:0, wb:0, ab:17'h0,     db:8'h00, ega:1, egb:0};
      vecs[1] = '{ra:0, aa:17'h0,     rb:1, wb:1, ab:17'h00010, db:8'h1F, ega:0, egb:1};
      vecs[2] = '{ra:0, aa:17'h0,     rb:1, wb:0, ab:17'h00010, db:8'h00, ega:0, egb:1};
      vecs[3] = '{ra:1, aa:17'h1ABCD, rb:1, wb:0, ab:17'h00044, db:8'h00, ega:1, egb:0};
      vecs[4] = '{ra:0, aa:17'h0,     rb:1, wb:0, ab:17'h1FFFF, db:8'h00, ega:0, egb:1};
      vecs[5] = '{ra:1, aa:17'h1FFFF, rb:0, wb:0, ab:17'h0,     db:8'h00, ega:1, egb:0};
      vecs[6] = '{ra:0, aa:17'h0,     rb:1, wb:1, ab:17'h00000, db:8'hAA, ega:0, egb:1};
      vecs[7] = '{ra:1, aa:17'h00000, rb:0, wb:0, ab:17'h0,     db:8'h00, ega:1, egb:0};

      // Reset state
      reset_model();
      repeat (2) @(posedge Clk);
      #1;
      req_a = 1'b1;
      chk_reset_outputs("por");
      req_a = 1'b0;
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;

      idle();
      foreach (vecs[i]) begin
         $display("[TB] vec %0d ra=%0b aa=%05h rb=%0b wb=%0b ab=%05h db=%02h", i,
                  vecs[i].ra, vecs[i].aa, vecs[i].rb, vecs[i].wb, vecs[i].ab, vecs[i].db);
         cycle(vecs[i].ra, vecs[i].aa, vecs[i].rb, vecs[i].wb, vecs[i].ab, vecs[i].db, 1'b0,
               vecs[i].ega, vecs[i].egb, $sformatf("vec%0d", i));
         idle();
      end
      chk("mem_write_landed", 32'(mem[17'h00010]), 32'h1F);

      // Starvation pattern: A,A,A,A,B repeating; run past 255 A denials.
      $display("[TB] seq starvation: 1300 cycles with req_a and req_b held");
      for (int i = 0; i < 1300; i++)
         cycle(1'b1, AW'(i * 37), 1'b1, 1'b0, 17'h00abc, 8'h00, 1'b0,
               (i % 5) != 4, (i % 5) == 4, $sformatf("starve%0d", i));
      chk("miss_sat", 32'(miss_cnt), 32'd255);

      // Clear coinciding with a denial wins.
      $display("[TB] seq miss_clr during a denial");
      for (int i = 0; i < 5; i++)
         cycle(1'b1, AW'(i + 5), 1'b1, 1'b0, 17'h00abc, 8'h00, i == 4,
               i != 4, i == 4, $sformatf("clr%0d", i));
      idle();
      chk("miss_cleared", 32'(miss_cnt), 32'd0);

      // Reset asserted the cycle after a port A grant.
      $display("[TB] seq reset mid-read");
      cycle(1'b1, 17'h00123, 1'b0, 1'b0, 17'h0, 8'h00, 1'b0, 1'b1, 1'b0, "pre_rst");
      req_a   = 1'b1;
      Reset_n = 1'b0;
      #1;
      chk_reset_outputs("rst_now");
      @(posedge Clk);
      #1;
      chk_reset_outputs("rst_hold");
      req_a = 1'b0;
      reset_model();
      Reset_n = 1'b1;
      idle();
      idle();
      cycle(1'b1, 17'h00123, 1'b0, 1'b0, 17'h0, 8'h00, 1'b0, 1'b1, 1'b0, "post_rst");
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
